// File: rtl/glyph_pkg.sv
// Shared glyph ROM geometry and digit-to-slot mapping for the digit display path.
package glyph_pkg;

  localparam int GLYPH_W         = 16;
  localparam int GLYPH_H         = 16;
  localparam int GLYPH_ROWS_LOG2 = 4;
  localparam int ZERO_SLOT       = 9;

  typedef struct packed {
    logic       valid;
    logic       in_window;
    logic       blank;
    logic [3:0] col;
    logic [7:0] rom_addr;
  } stage1_t;

  // ROM stores glyphs 1..9 first, then 0.
  function automatic logic [3:0] digit_to_slot(input logic [3:0] d);
    if (d == 4'd0) digit_to_slot = 4'(ZERO_SLOT);
    else           digit_to_slot = d - 4'd1;
  endfunction

endpackage

// File: rtl/blink_timer.sv
// Frame counter for the cursor blink; phase flips every BLINK_FRAMES frame starts.
module blink_timer #(
  parameter int BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_start,
  output logic blink_phase
);

  localparam int CTR_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CTR_W-1:0] CTR_MAX = CTR_W'(BLINK_FRAMES - 1);

  logic [CTR_W-1:0] ctr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr         <= '0;
      blink_phase <= 1'b0;
    end else if (frame_start) begin
      if (ctr == CTR_MAX) begin
        ctr         <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        ctr <= ctr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/digit_renderer.sv
// Maps the raster stream onto a row of scaled digit glyphs, addresses the glyph ROM
// and turns the returned row into a per-pixel mask two cycles later.
module digit_renderer
  import glyph_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCALE_LOG2   = 1,
  parameter int X0           = 192,
  parameter int Y0           = 208,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          frame_start,
  input  logic                          pix_valid,
  input  logic [9:0]                    pix_x,
  input  logic [9:0]                    pix_y,
  input  logic [4*NUM_DIGITS-1:0]       digits,
  input  logic                          cursor_en,
  input  logic [$clog2(NUM_DIGITS)-1:0] cursor_idx,
  output logic [7:0]                    rom_addr,
  input  logic [15:0]                   rom_data,
  output logic                          pix_on,
  output logic                          pix_on_valid
);

  localparam int PITCH_LOG2 = $clog2(GLYPH_W) + SCALE_LOG2;
  localparam int PITCH      = GLYPH_W << SCALE_LOG2;
  localparam int X_END      = X0 + NUM_DIGITS * PITCH;
  localparam int Y_END      = Y0 + (GLYPH_H << SCALE_LOG2);

  logic [4*NUM_DIGITS-1:0] shadow;
  logic                    blink_phase;

  logic [9:0] dx;
  logic [9:0] dy;
  logic [9:0] kfull;
  logic [3:0] col;
  logic [GLYPH_ROWS_LOG2-1:0] row;
  logic [3:0] dval;
  logic       in_window;
  logic       cursor_hit;
  logic       blank;
  logic [7:0] addr_next;

  stage1_t s1;

  blink_timer #(
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_blink_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .blink_phase (blink_phase)
  );

  // Digits only change at frame boundaries so a frame never shows two values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) shadow <= '1;
    else if (frame_start) shadow <= digits;
  end

  always_comb begin
    in_window = (int'(pix_x) >= X0) && (int'(pix_x) < X_END) &&
                (int'(pix_y) >= Y0) && (int'(pix_y) < Y_END);
    dx    = pix_x - 10'(X0);
    dy    = pix_y - 10'(Y0);
    kfull = dx >> PITCH_LOG2;
    col   = 4'((dx & 10'(PITCH - 1)) >> SCALE_LOG2);
    row   = GLYPH_ROWS_LOG2'(dy >> SCALE_LOG2);
    dval  = 4'hF;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (kfull == 10'(i)) dval = shadow[4*i +: 4];
    end
    cursor_hit = cursor_en && blink_phase && (kfull == 10'(cursor_idx));
    blank      = (dval > 4'd9) || cursor_hit;
    addr_next  = (in_window && (dval <= 4'd9)) ? {digit_to_slot(dval), row} : 8'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
    end else begin
      s1 <= '{valid: pix_valid, in_window: in_window, blank: blank,
              col: col, rom_addr: addr_next};
    end
  end

  assign rom_addr = s1.rom_addr;

  // ROM is combinational, so its row is ready to sample in the cycle after addressing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_on       <= 1'b0;
      pix_on_valid <= 1'b0;
    end else begin
      pix_on       <= s1.valid & s1.in_window & ~s1.blank & rom_data[4'd15 - s1.col];
      pix_on_valid <= s1.valid;
    end
  end

endmodule
